// File: rtl/ci_fir_mac.sv
// Nios II multicycle custom instruction: N-tap FIR with one shared MAC stepping a tap per cycle.
// Opcodes on n: PUSH sample, WCOEF write coefficient, CLEAR delay line, RCOEF read coefficient.
module ci_fir_mac #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned COEF_W = 16,
  parameter int unsigned TAPS   = 16,
  parameter int unsigned SHIFT  = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_en,
  input  logic        start,
  input  logic [1:0]  n,
  input  logic [31:0] dataa,
  input  logic [31:0] datab,
  output logic [31:0] result,
  output logic        done
);

  localparam int unsigned PTR_W  = (TAPS > 1) ? $clog2(TAPS) : 1;
  localparam int unsigned PROD_W = DATA_W + COEF_W;
  localparam int unsigned ACC_W  = PROD_W + $clog2(TAPS);
  localparam int unsigned EXT_W  = (ACC_W > 32) ? ACC_W : 33;
  localparam logic [PTR_W-1:0] LAST = PTR_W'(TAPS - 1);

  localparam logic [1:0] OP_PUSH  = 2'd0;
  localparam logic [1:0] OP_WCOEF = 2'd1;
  localparam logic [1:0] OP_CLEAR = 2'd2;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MAC  = 2'd1;
  localparam logic [1:0] S_CLR  = 2'd2;
  localparam logic [1:0] S_RSP  = 2'd3;

  logic [1:0]               state_q, state_d;
  logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]         k_q, k_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [31:0]              result_d;
  logic                     done_q, done_d;

  logic signed [DATA_W-1:0] x_mem    [TAPS];
  logic signed [COEF_W-1:0] coef_mem [TAPS];

  logic                     x_we;
  logic [PTR_W-1:0]         x_waddr;
  logic signed [DATA_W-1:0] x_wdata;
  logic                     c_we;

  logic [PTR_W-1:0]         idx;
  logic                     idx_ok;
  logic [PTR_W-1:0]         rd_idx;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  acc_sum;
  logic signed [EXT_W-1:0]  acc_sh;
  logic [EXT_W-32:0]        sat_hi;
  logic [31:0]              sat_c;
  logic                     unused_ok;

  assign unused_ok = &{1'b0, dataa};

  assign idx    = datab[PTR_W-1:0];
  assign idx_ok = datab < 32'(TAPS);

  // Newest sample sits at wr_ptr; tap k reads (wr_ptr - k) mod TAPS
  assign rd_idx  = (wr_ptr_q >= k_q) ? (wr_ptr_q - k_q) : (wr_ptr_q + PTR_W'(TAPS) - k_q);
  assign prod    = PROD_W'(x_mem[rd_idx]) * PROD_W'(coef_mem[k_q]);
  assign acc_sum = acc_q + ACC_W'(prod);
  assign acc_sh  = EXT_W'(acc_sum) >>> SHIFT;
  assign sat_hi  = acc_sh[EXT_W-1:31];
  assign sat_c   = ((&sat_hi) || !(|sat_hi)) ? acc_sh[31:0]
                 : (acc_sh[EXT_W-1] ? 32'h8000_0000 : 32'h7FFF_FFFF);

  assign done = done_q & clk_en;

  // Next-state and datapath control
  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    k_d      = k_q;
    acc_d    = acc_q;
    result_d = result;
    x_we     = 1'b0;
    x_waddr  = wr_ptr_q;
    x_wdata  = dataa[DATA_W-1:0];
    c_we     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          case (n)
            OP_PUSH: begin
              x_we    = 1'b1;
              acc_d   = '0;
              k_d     = '0;
              state_d = S_MAC;
            end
            OP_WCOEF: begin
              c_we     = idx_ok;
              result_d = '0;
              state_d  = S_RSP;
            end
            OP_CLEAR: begin
              k_d     = '0;
              state_d = S_CLR;
            end
            default: begin
              result_d = idx_ok ? 32'(coef_mem[idx]) : 32'h0;
              state_d  = S_RSP;
            end
          endcase
        end
      end
      S_MAC: begin
        acc_d = acc_sum;
        k_d   = k_q + PTR_W'(1);
        if (k_q == LAST) begin
          result_d = sat_c;
          wr_ptr_d = (wr_ptr_q == LAST) ? '0 : wr_ptr_q + PTR_W'(1);
          state_d  = S_RSP;
        end
      end
      S_CLR: begin
        x_we    = 1'b1;
        x_waddr = k_q;
        x_wdata = '0;
        k_d     = k_q + PTR_W'(1);
        if (k_q == LAST) begin
          wr_ptr_d = '0;
          result_d = '0;
          state_d  = S_RSP;
        end
      end
      default: state_d = S_IDLE;
    endcase
    done_d = (state_d == S_RSP);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      k_q      <= '0;
      acc_q    <= '0;
      result   <= '0;
      done_q   <= 1'b0;
    end else if (clk_en) begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      k_q      <= k_d;
      acc_q    <= acc_d;
      result   <= result_d;
      done_q   <= done_d;
    end
  end

  // Delay line and coefficient stores: at most one write each per cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(TAPS); i++) begin
        x_mem[i]    <= '0;
        coef_mem[i] <= '0;
      end
    end else if (clk_en) begin
      if (x_we) x_mem[x_waddr] <= x_wdata;
      if (c_we) coef_mem[idx] <= dataa[COEF_W-1:0];
    end
  end

endmodule
